rob_wb_arbiter: RTL and testbench

- Shares the single ROB writeback/completion port between NUM_REQ execution units (ALU, LSU, branch unit).
- Each requester has a one-entry holding register. Requesters get a valid/ready handshake.
- One pending completion per cycle is granted round-robin to the ROB wb inputs.
- A flush from the commit stage (taken branch) discards all pending completions.

---
 rtl/rob_wb_arbiter.sv | 139 +++++++++++++
 tb/tb_rob_wb_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rob_wb_arbiter.sv
// Round-robin arbiter sharing the single ROB writeback port between NUM_REQ
// execution units, each buffered by a one-entry holding register.
module rob_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int CNT_W   = 16,
  parameter int IDX_W   = 6,
  parameter int DATA_W  = 32
) (
  input  logic                             clk_i,
  input  logic                             rstn_i,
  input  logic                             flush_i,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  input  logic [NUM_REQ-1:0][IDX_W-1:0]    req_rob_idx_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_result_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_new_pc_i,
  input  logic [NUM_REQ-1:0]               req_branch_taken_i,
  output logic                             wb_valid_o,
  output logic [IDX_W-1:0]                 wb_rob_idx_o,
  output logic [DATA_W-1:0]                wb_result_o,
  output logic [DATA_W-1:0]                wb_new_pc_o,
  output logic                             wb_branch_taken_o,
  output logic [NUM_REQ-1:0]               wb_grant_o,
  output logic [CNT_W-1:0]                 conflict_cnt_o
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]             pend_q, pend_d;
  logic [NUM_REQ-1:0][IDX_W-1:0]  idx_q, idx_d;
  logic [NUM_REQ-1:0][DATA_W-1:0] res_q, res_d;
  logic [NUM_REQ-1:0][DATA_W-1:0] pc_q, pc_d;
  logic [NUM_REQ-1:0]             tk_q, tk_d;
  logic [PTR_W-1:0]               rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;

  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] acc;
  logic [PTR_W-1:0]   gnt_idx;
  logic               gnt_vld;
  int                 npend;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Grant search uses registered state only, so a new input never bypasses
  // its holding register.
  always_comb begin
    int j;
    grant   = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    j       = 0;
    if (!flush_i) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        j = int'(rr_ptr_q) + k;
        if (j >= NUM_REQ) j = j - NUM_REQ;
        if (!gnt_vld && pend_q[j]) begin
          gnt_vld  = 1'b1;
          gnt_idx  = PTR_W'(j);
          grant[j] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    npend = 0;
    for (int i = 0; i < NUM_REQ; i++) npend = npend + int'(pend_q[i]);
  end

  assign req_ready_o    = ~pend_q | grant;
  assign acc            = req_valid_i & req_ready_o & {NUM_REQ{~flush_i}};
  assign wb_valid_o     = gnt_vld;
  assign wb_grant_o     = grant;
  assign conflict_cnt_o = cnt_q;

  always_comb begin
    wb_rob_idx_o      = '0;
    wb_result_o       = '0;
    wb_new_pc_o       = '0;
    wb_branch_taken_o = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        wb_rob_idx_o      = idx_q[i];
        wb_result_o       = res_q[i];
        wb_new_pc_o       = pc_q[i];
        wb_branch_taken_o = tk_q[i];
      end
    end
  end

  always_comb begin
    pend_d   = pend_q;
    idx_d    = idx_q;
    res_d    = res_q;
    pc_d     = pc_q;
    tk_d     = tk_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (acc[i]) begin
        pend_d[i] = 1'b1;
        idx_d[i]  = req_rob_idx_i[i];
        res_d[i]  = req_result_i[i];
        pc_d[i]   = req_new_pc_i[i];
        tk_d[i]   = req_branch_taken_i[i];
      end else if (grant[i]) begin
        pend_d[i] = 1'b0;
      end
    end
    if (gnt_vld) rr_ptr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
    if (flush_i) begin
      pend_d   = '0;
      rr_ptr_d = '0;
    end
    if (npend >= 2) cnt_d = sat_inc(cnt_q);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      pend_q   <= '0;
      idx_q    <= '0;
      res_q    <= '0;
      pc_q     <= '0;
      tk_q     <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      pend_q   <= pend_d;
      idx_q    <= idx_d;
      res_q    <= res_d;
      pc_q     <= pc_d;
      tk_q     <= tk_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Bench for rob_wb_arbiter: vector table for per-cycle outputs plus a
// per-requester payload scoreboard and hand-written corner sequences.
module tb_rob_wb_arbiter;
  logic              clk_i = 1'b0;
  logic              rstn_i;
  logic              flush_i;
  logic [2:0]        req_valid_i;
  logic [2:0]        req_ready_o;
  logic [2:0][5:0]   req_rob_idx_i;
  logic [2:0][31:0]  req_result_i;
  logic [2:0][31:0]  req_new_pc_i;
  logic [2:0]        req_branch_taken_i;
  logic              wb_valid_o;
  logic [5:0]        wb_rob_idx_o;
  logic [31:0]       wb_result_o;
  logic [31:0]       wb_new_pc_o;
  logic              wb_branch_taken_o;
  logic [2:0]        wb_grant_o;
  logic [15:0]       conflict_cnt_o;

  rob_wb_arbiter #(.NUM_REQ(3), .CNT_W(16), .IDX_W(6), .DATA_W(32)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_rob_idx_i(req_rob_idx_i), .req_result_i(req_result_i),
    .req_new_pc_i(req_new_pc_i), .req_branch_taken_i(req_branch_taken_i),
    .wb_valid_o(wb_valid_o), .wb_rob_idx_o(wb_rob_idx_o),
    .wb_result_o(wb_result_o), .wb_new_pc_o(wb_new_pc_o),
    .wb_branch_taken_o(wb_branch_taken_o), .wb_grant_o(wb_grant_o),
    .conflict_cnt_o(conflict_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0]      valid;
    logic            flush;
    logic [2:0][5:0] idx;
    logic            ewv;
    logic [2:0]      egnt;
    logic [2:0]      erdy;
    logic [5:0]      eidx;
    logic [15:0]     ecnt;
  } vec_t;

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] res;
    logic [31:0] pc;
    logic        tk;
  } pl_t;

  vec_t vecs[$];
  pl_t  sbq[3][$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [31:0] res_of(int r, logic [5:0] idx);
    return 32'hDEADBEEA ^ {26'd0, idx} ^ (32'(r) << 8);
  endfunction

  function automatic logic [31:0] pc_of(int r, logic [5:0] idx);
    return 32'h1000 + {24'd0, idx, 2'b00} + (32'(r) << 8);
  endfunction

  function automatic logic tk_of(int r, logic [5:0] idx);
    return idx[0] ^ r[0];
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic f, input logic [5:0] i0,
                       input logic [5:0] i1, input logic [5:0] i2);
    logic [2:0][5:0] ix;
    ix = {i2, i1, i0};
    req_valid_i = v;
    flush_i     = f;
    for (int r = 0; r < 3; r++) begin
      req_rob_idx_i[r]      = ix[r];
      req_result_i[r]       = res_of(r, ix[r]);
      req_new_pc_i[r]       = pc_of(r, ix[r]);
      req_branch_taken_i[r] = tk_of(r, ix[r]);
    end
  endtask

  task automatic add(input logic [2:0] v, input logic f, input logic [5:0] i0,
                     input logic [5:0] i1, input logic [5:0] i2, input logic ewv,
                     input logic [2:0] eg, input logic [2:0] er, input logic [5:0] ei,
                     input logic [15:0] ec);
    vec_t t;
    t.valid = v; t.flush = f; t.idx = {i2, i1, i0};
    t.ewv = ewv; t.egnt = eg; t.erdy = er; t.eidx = ei; t.ecnt = ec;
    vecs.push_back(t);
  endtask

  // Scoreboard update for the current cycle, then advance one clock.
  task automatic tick();
    pl_t e;
    pl_t a;
    int  g;
    #1;
    if (wb_valid_o) begin
      g = -1;
      for (int i = 0; i < 3; i++) if (wb_grant_o[i]) g = i;
      chk("grant_onehot", 80'($onehot(wb_grant_o)), 80'd1);
      if (g < 0 || sbq[g].size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected grant=%b idx=%0d expected no writeback", wb_grant_o, wb_rob_idx_o);
      end else begin
        e = sbq[g].pop_front();
        a = {wb_rob_idx_o, wb_result_o, wb_new_pc_o, wb_branch_taken_o};
        chk("sb_payload", 80'(a), 80'(e));
      end
    end
    if (!rstn_i || flush_i) begin
      for (int i = 0; i < 3; i++) sbq[i].delete();
    end else begin
      for (int i = 0; i < 3; i++)
        if (req_valid_i[i] && req_ready_o[i])
          sbq[i].push_back({req_rob_idx_i[i], req_result_i[i], req_new_pc_i[i], req_branch_taken_i[i]});
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rstn_i = 1'b0;
    drive(3'b000, 1'b0, 6'd0, 6'd0, 6'd0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    chk("rst_wb_valid", 80'(wb_valid_o), 80'd0);
    chk("rst_grant",    80'(wb_grant_o), 80'd0);
    chk("rst_ready",    80'(req_ready_o), 80'b111);
    chk("rst_cnt",      80'(conflict_cnt_o), 80'd0);
    chk("rst_result",   80'(wb_result_o), 80'd0);
    rstn_i = 1'b1;

    //   valid  fl  i0 i1 i2   wv  grant  ready  idx cnt
    add(3'b001, 0, 5, 0, 0,   0, 3'b000, 3'b111, 0, 0);
    add(3'b000, 0, 0, 0, 0,   1, 3'b001, 3'b111, 5, 0);
    add(3'b000, 0, 0, 0, 0,   0, 3'b000, 3'b111, 0, 0);
    add(3'b000, 1, 0, 0, 0,   0, 3'b000, 3'b111, 0, 0);
    add(3'b111, 0, 0, 1, 2,   0, 3'b000, 3'b111, 0, 0);
    add(3'b111, 0, 0, 1, 2,   1, 3'b001, 3'b001, 0, 0);
    add(3'b111, 0, 0, 1, 2,   1, 3'b010, 3'b010, 1, 1);
    add(3'b111, 0, 0, 1, 2,   1, 3'b100, 3'b100, 2, 2);
    add(3'b111, 0, 0, 1, 2,   1, 3'b001, 3'b001, 0, 3);
    add(3'b111, 0, 0, 1, 2,   1, 3'b010, 3'b010, 1, 4);
    add(3'b111, 0, 0, 1, 2,   1, 3'b100, 3'b100, 2, 5);
    add(3'b000, 0, 0, 0, 0,   1, 3'b001, 3'b001, 0, 6);
    add(3'b000, 0, 0, 0, 0,   1, 3'b010, 3'b011, 1, 7);
    add(3'b000, 0, 0, 0, 0,   1, 3'b100, 3'b111, 2, 8);
    add(3'b010, 0, 0, 2, 0,   0, 3'b000, 3'b111, 0, 8);
    add(3'b010, 0, 0, 3, 0,   1, 3'b010, 3'b111, 2, 8);
    add(3'b010, 0, 0, 4, 0,   1, 3'b010, 3'b111, 3, 8);
    add(3'b000, 0, 0, 0, 0,   1, 3'b010, 3'b111, 4, 8);
    add(3'b000, 0, 0, 0, 0,   0, 3'b000, 3'b111, 0, 8);
    add(3'b101, 0, 7, 0, 9,   0, 3'b000, 3'b111, 0, 8);
    add(3'b010, 1, 0, 11, 0,  0, 3'b000, 3'b010, 0, 8);
    add(3'b000, 0, 0, 0, 0,   0, 3'b000, 3'b111, 0, 9);
    add(3'b111, 0, 1, 2, 3,   0, 3'b000, 3'b111, 0, 9);
    add(3'b000, 0, 0, 0, 0,   1, 3'b001, 3'b001, 1, 9);
    add(3'b000, 0, 0, 0, 0,   1, 3'b010, 3'b011, 2, 10);
    add(3'b000, 0, 0, 0, 0,   1, 3'b100, 3'b111, 3, 11);

    foreach (vecs[n]) begin
      drive(vecs[n].valid, vecs[n].flush, vecs[n].idx[0], vecs[n].idx[1], vecs[n].idx[2]);
      #1;
      chk($sformatf("v%0d_wb_valid", n), 80'(wb_valid_o), 80'(vecs[n].ewv));
      chk($sformatf("v%0d_grant", n),    80'(wb_grant_o), 80'(vecs[n].egnt));
      chk($sformatf("v%0d_ready", n),    80'(req_ready_o), 80'(vecs[n].erdy));
      chk($sformatf("v%0d_idx", n),      80'(wb_rob_idx_o), 80'(vecs[n].eidx));
      chk($sformatf("v%0d_cnt", n),      80'(conflict_cnt_o), 80'(vecs[n].ecnt));
      tick();
    end
    chk("sb_drained", 80'(sbq[0].size() + sbq[1].size() + sbq[2].size()), 80'd0);

    // Saturate the conflict counter under full contention.
    drive(3'b111, 1'b0, 6'd10, 6'd11, 6'd12);
    repeat (65545) tick();
    chk("cnt_saturated", 80'(conflict_cnt_o), 80'hFFFF);
    tick();
    chk("cnt_no_wrap", 80'(conflict_cnt_o), 80'hFFFF);

    // Reset with all three slots pending.
    drive(3'b000, 1'b0, 6'd0, 6'd0, 6'd0);
    rstn_i = 1'b0;
    tick();
    rstn_i = 1'b1;
    #1;
    chk("rst2_wb_valid", 80'(wb_valid_o), 80'd0);
    chk("rst2_grant",    80'(wb_grant_o), 80'd0);
    chk("rst2_ready",    80'(req_ready_o), 80'b111);
    chk("rst2_idx",      80'(wb_rob_idx_o), 80'd0);
    chk("rst2_result",   80'(wb_result_o), 80'd0);
    chk("rst2_pc",       80'(wb_new_pc_o), 80'd0);
    chk("rst2_taken",    80'(wb_branch_taken_o), 80'd0);
    chk("rst2_cnt",      80'(conflict_cnt_o), 80'd0);
    tick();
    chk("rst2_dropped", 80'(wb_valid_o), 80'd0);

    // Flush together with reset: reset wins, so the counter clears too.
    drive(3'b111, 1'b0, 6'd20, 6'd21, 6'd22);
    tick();
    drive(3'b000, 1'b0, 6'd0, 6'd0, 6'd0);
    tick();
    chk("pre_rf_cnt", 80'(conflict_cnt_o), 80'd1);
    rstn_i  = 1'b0;
    flush_i = 1'b1;
    tick();
    rstn_i  = 1'b1;
    flush_i = 1'b0;
    #1;
    chk("rf_cnt",   80'(conflict_cnt_o), 80'd0);
    chk("rf_ready", 80'(req_ready_o), 80'b111);
    chk("rf_valid", 80'(wb_valid_o), 80'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
